// File: rtl/uart_pixel_deframer_pkg.sv
// uart_pixel_deframer_pkg: shared types and defaults for the UART pixel deframer
package uart_pixel_deframer_pkg;
   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;
   typedef enum logic [2:0] {S_HUNT, S_W_HI, S_W_LO, S_H_HI, S_H_LO, S_PIX, S_CSUM} deframe_state_t;
   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              sof;
      logic              eol;
      logic              eof;
   } pix_beat_t;
endpackage

// File: rtl/uart_pixel_deframer_if.sv
// uart_pixel_deframer_if: RX FIFO read side and pixel stream bundled for the deframer
interface uart_pixel_deframer_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] rx_rd_data;
   logic              rx_valid;
   logic              rx_rd;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_sof;
   logic              pix_eol;
   logic              pix_eof;
   modport master (
      input  rx_rd_data, rx_valid, pix_ready,
      output rx_rd, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
   );
   modport slave (
      output rx_rd_data, rx_valid, pix_ready,
      input  rx_rd, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
   );
endinterface

// File: rtl/uart_pixel_deframer_pix_out_reg.sv
// uart_pixel_deframer_pix_out_reg: one-entry valid/ready register holding a pixel beat
module uart_pixel_deframer_pix_out_reg
   import uart_pixel_deframer_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      ld,
   input  logic      ready,
   input  pix_beat_t beat_in,
   output logic      valid,
   output pix_beat_t beat
);
   // load only happens when empty or draining, so a stalled beat never changes
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         beat <= '0;
      end else if (ld) begin
         valid <= 1'b1;
         beat <= beat_in;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/uart_pixel_deframer.sv
// uart_pixel_deframer: sync hunt, header parse, pixel streaming, checksum and idle timeout
module uart_pixel_deframer
   import uart_pixel_deframer_pkg::*;
#(
   parameter int                DATA_W      = BYTE_W,
   parameter int                MAX_W       = 1024,
   parameter int                MAX_H       = 1024,
   parameter logic [DATA_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int                TIMEOUT_CYC = 100000
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_pixel_deframer_if.master bus,
   output logic [15:0]          frame_width,
   output logic [15:0]          frame_height,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 hdr_err,
   output logic                 csum_err,
   output logic                 timeout_err
);
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   deframe_state_t    state, state_nxt;
   logic [15:0]       w_tmp, h_val, col, row;
   logic [DATA_W-1:0] h_hi, csum, d;
   logic [IDLE_W-1:0] idle;
   logic              accept, pop, ld, hdr_bad, tmo, pv;
   pix_beat_t         beat_in, pb;
   assign d = bus.rx_rd_data;
   assign busy = state != S_HUNT;
   assign bus.rx_rd = pop;
   assign bus.pix_valid = pv;
   assign bus.pix_data = pb.data;
   assign bus.pix_sof = pb.sof;
   assign bus.pix_eol = pb.eol;
   assign bus.pix_eof = pb.eof;
   // next state, pop strobe, header check and the beat that a pixel pop would load
   always_comb begin
      accept = (state != S_PIX) | !pv | bus.pix_ready;
      pop = bus.rx_valid & accept;
      ld = pop & (state == S_PIX);
      h_val = {h_hi, d};
      hdr_bad = (w_tmp == 16'd0) | (h_val == 16'd0) | (w_tmp > 16'(MAX_W)) | (h_val > 16'(MAX_H));
      beat_in.data = d;
      beat_in.sof = (row == 16'd0) & (col == 16'd0);
      beat_in.eol = col == frame_width - 16'd1;
      beat_in.eof = beat_in.eol & (row == frame_height - 16'd1);
      tmo = (state != S_HUNT) & !bus.rx_valid & (idle == IDLE_W'(TIMEOUT_CYC - 1));
      state_nxt = state;
      if (pop) begin
         case (state)
            S_HUNT:  state_nxt = (d == SYNC_BYTE) ? S_W_HI : S_HUNT;
            S_W_HI:  state_nxt = S_W_LO;
            S_W_LO:  state_nxt = S_H_HI;
            S_H_HI:  state_nxt = S_H_LO;
            S_H_LO:  state_nxt = hdr_bad ? S_HUNT : S_PIX;
            S_PIX:   state_nxt = beat_in.eof ? S_CSUM : S_PIX;
            default: state_nxt = S_HUNT;
         endcase
      end else if (tmo) begin
         state_nxt = S_HUNT;
      end
   end
   // state register
   always_ff @(posedge clk) state <= rst ? S_HUNT : state_nxt;
   // header capture, pixel counters, checksum, idle timer and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         w_tmp <= '0;
         h_hi <= '0;
         frame_width <= '0;
         frame_height <= '0;
         col <= '0;
         row <= '0;
         csum <= '0;
         idle <= '0;
         frame_done <= 1'b0;
         hdr_err <= 1'b0;
         csum_err <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         frame_done <= pop & (state == S_CSUM);
         csum_err <= pop & (state == S_CSUM) & (d != csum);
         hdr_err <= pop & (state == S_H_LO) & hdr_bad;
         timeout_err <= tmo;
         idle <= (pop | tmo | (state == S_HUNT)) ? '0 : idle + IDLE_W'(!bus.rx_valid);
         if (pop) begin
            case (state)
               S_W_HI: w_tmp[15:8] <= d;
               S_W_LO: w_tmp[7:0] <= d;
               S_H_HI: h_hi <= d;
               S_H_LO: begin
                  col <= '0;
                  row <= '0;
                  csum <= '0;
                  if (!hdr_bad) begin
                     frame_width <= w_tmp;
                     frame_height <= h_val;
                  end
               end
               S_PIX: begin
                  csum <= csum ^ d;
                  col <= beat_in.eol ? 16'd0 : col + 16'd1;
                  row <= beat_in.eol ? row + 16'd1 : row;
               end
               default: ;
            endcase
         end
      end
   end
   uart_pixel_deframer_pix_out_reg u_pix_out_reg (
      .clk    (clk),
      .rst    (rst),
      .ld     (ld),
      .ready  (bus.pix_ready),
      .beat_in(beat_in),
      .valid  (pv),
      .beat   (pb)
   );
endmodule

// File: tb/tb_uart_pixel_deframer.sv
// tb_uart_pixel_deframer: random frames through a show-ahead FIFO model, checked against a frame-level model
module tb_uart_pixel_deframer;
   import uart_pixel_deframer_pkg::*;
   localparam int MW = 16;
   localparam int MH = 8;
   localparam int TO = 64;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] frame_width, frame_height;
   logic        busy, frame_done, hdr_err, csum_err, timeout_err;
   logic [7:0]  fifo[$];
   logic [10:0] exp_q[$];
   logic [10:0] log_q[$];
   logic [10:0] held_beat;
   logic        pop_q = 1'b0;
   logic        gap_rnd = 1'b0, rdy_rnd = 1'b0, logging = 1'b0;
   logic        pend = 1'b0, held = 1'b0, in_stall = 1'b0;
   int          n_cmp = 0, n_bad = 0;
   int          n_done = 0, n_csum = 0, n_hdr = 0, n_tmo = 0, n_both = 0;
   int          e_done = 0, e_csum = 0, e_hdr = 0, e_tmo = 0, e_w = 0, e_h = 0;
   int          stall_at = 0, stall_left = 0, acc_done = 0;

   uart_pixel_deframer_if #(.DATA_W(8)) bus ();

   uart_pixel_deframer #(
      .DATA_W(8), .MAX_W(MW), .MAX_H(MH), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .frame_width(frame_width), .frame_height(frame_height),
      .busy(busy), .frame_done(frame_done), .hdr_err(hdr_err), .csum_err(csum_err),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [7:0] seq_csum(input int n);
      logic [7:0] c = 8'h00;
      for (int i = 0; i < n; i++) c ^= 8'(i + 1);
      return c;
   endfunction

   // frame-level model: bytes to the FIFO, beats to the expectation queue
   task automatic send_frame(input int w, input int h, input bit bad, input bit seq, input int npix);
      logic [7:0] px;
      logic [7:0] cs = 8'h00;
      int n = w * h;
      int k = (npix < 0) ? n : npix;
      fifo.push_back(8'hA5);
      fifo.push_back(8'(w >> 8));
      fifo.push_back(8'(w));
      fifo.push_back(8'(h >> 8));
      fifo.push_back(8'(h));
      e_w = w;
      e_h = h;
      for (int i = 0; i < k; i++) begin
         px = seq ? 8'(i + 1) : 8'($urandom);
         cs ^= px;
         fifo.push_back(px);
         exp_q.push_back({px, i == 0, (i % w) == w - 1, i == n - 1});
      end
      if (k == n) begin
         fifo.push_back(bad ? cs ^ 8'h01 : cs);
         e_done++;
         e_csum += int'(bad);
      end
   endtask

   task automatic send_hdr(input int w, input int h);
      fifo.push_back(8'hA5);
      fifo.push_back(8'(w >> 8));
      fifo.push_back(8'(w));
      fifo.push_back(8'(h >> 8));
      fifo.push_back(8'(h));
      e_hdr++;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while ((fifo.size() > 0 || exp_q.size() > 0 || busy || bus.pix_valid) && k < 4000) begin
         tick();
         k++;
      end
      repeat (3) tick();
      chk({name, "_drained"}, 32'(k < 4000), 1);
   endtask

   task automatic check_counts(input string s);
      chk({s, "_done"}, n_done, e_done);
      chk({s, "_csum_err"}, n_csum, e_csum);
      chk({s, "_done_csum_same_clk"}, n_both, e_csum);
      chk({s, "_hdr_err"}, n_hdr, e_hdr);
      chk({s, "_timeout_err"}, n_tmo, e_tmo);
      chk({s, "_frame_width"}, frame_width, e_w);
      chk({s, "_frame_height"}, frame_height, e_h);
   endtask

   always @(posedge clk) pop_q <= bus.rx_rd & bus.rx_valid;

   // FIFO model, ready control and the per-cycle output compare
   always @(negedge clk) begin
      logic [10:0] cur;
      cur = {bus.pix_data, bus.pix_sof, bus.pix_eol, bus.pix_eof};
      if (rst) begin
         held = 1'b0;
         pend = 1'b0;
         in_stall = 1'b0;
         stall_left = 0;
         bus.pix_ready = 1'b1;
      end else begin
         n_done += int'(frame_done);
         n_csum += int'(csum_err);
         n_hdr += int'(hdr_err);
         n_tmo += int'(timeout_err);
         n_both += int'(frame_done & csum_err);
         if (held) chk("held_beat", {bus.pix_valid, cur}, {1'b1, held_beat});
         if (in_stall && bus.pix_valid) chk("rx_rd_while_stalled", bus.rx_rd, 0);
         acc_done += int'(pend);
         pend = 1'b0;
         if (stall_at > 0 && acc_done == stall_at) begin
            stall_left = 5;
            stall_at = 0;
         end
         in_stall = stall_left > 0;
         if (stall_left > 0) begin
            bus.pix_ready = 1'b0;
            stall_left--;
         end else begin
            bus.pix_ready = rdy_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         if (bus.pix_valid && bus.pix_ready) begin
            pend = 1'b1;
            if (logging) log_q.push_back(cur);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL beat_unexpected: got %h required none", cur);
            end else begin
               chk("beat", cur, exp_q.pop_front());
            end
         end
         held = bus.pix_valid && !bus.pix_ready;
         held_beat = cur;
      end
      if (pop_q && fifo.size() > 0) void'(fifo.pop_front());
      if (rst) fifo.delete();
      bus.rx_valid = fifo.size() > 0 && !rst && (!gap_rnd || $urandom_range(0, 3) != 0);
      bus.rx_rd_data = fifo.size() > 0 ? fifo[0] : 8'h00;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, w, h, kind, prev;
      logic [7:0] nb;
      repeat (3) tick();
      chk("reset_flags", {bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof, busy,
                          frame_done, hdr_err, csum_err, timeout_err}, 0);
      chk("reset_data", bus.pix_data, 0);
      chk("reset_dims", {frame_width, frame_height}, 0);
      chk("model_csum_pin", seq_csum(8), 8'h08);
      rst = 1'b0;
      tick();
      // basic 4x2 frame
      logging = 1'b1;
      send_frame(4, 2, 0, 1, -1);
      wait_done("s1");
      logging = 1'b0;
      chk("s1_beats", log_q.size(), 8);
      chk("s1_beat1", log_q[0], {8'h01, 3'b100});
      chk("s1_beat4", log_q[3], {8'h04, 3'b010});
      chk("s1_beat8", log_q[7], {8'h08, 3'b011});
      chk("s1_width_lit", frame_width, 16'd4);
      chk("s1_height_lit", frame_height, 16'd2);
      check_counts("s1");
      // leading junk dropped in hunt
      fifo.push_back(8'h00);
      fifo.push_back(8'hFF);
      fifo.push_back(8'h3C);
      send_frame(4, 2, 0, 1, -1);
      wait_done("s2");
      check_counts("s2");
      // downstream stall after the third beat
      stall_at = acc_done + 3;
      send_frame(4, 2, 0, 1, -1);
      wait_done("s3");
      chk("s3_stall_used", stall_at, 0);
      check_counts("s3");
      // bad checksum, then bad headers and size boundaries
      send_frame(4, 2, 1, 1, -1);
      wait_done("s4");
      check_counts("s4");
      send_hdr(0, 2);
      wait_done("s4_hdr0");
      chk("s4_busy_after_hdr", busy, 0);
      check_counts("s4_hdr0");
      send_hdr(MW + 1, 2);
      send_hdr(4, MH + 1);
      send_hdr(4, 0);
      wait_done("hdr_bounds");
      check_counts("hdr_bounds");
      send_frame(MW, MH, 0, 0, -1);
      wait_done("max_frame");
      check_counts("max_frame");
      send_frame(1, 1, 0, 0, -1);
      wait_done("one_pixel");
      check_counts("one_pixel");
      // truncated frame times out
      send_frame(4, 2, 0, 1, 3);
      k = 0;
      while (fifo.size() > 0 && k < 200) begin
         tick();
         k++;
      end
      k = 0;
      while (!timeout_err && k < 200) begin
         tick();
         k++;
      end
      chk("s5_timeout_latency", k, TO);
      e_tmo++;
      wait_done("s5");
      check_counts("s5");
      send_frame(4, 2, 0, 1, -1);
      wait_done("s5_next");
      check_counts("s5_next");
      // reset in the middle of a frame
      prev = acc_done;
      send_frame(4, 2, 0, 1, -1);
      k = 0;
      while (acc_done < prev + 2 && k < 500) begin
         tick();
         k++;
      end
      chk("s6_reached_midframe", 32'(k < 500), 1);
      rst = 1'b1;
      exp_q.delete();
      e_done--;
      e_w = 0;
      e_h = 0;
      tick();
      chk("s6_rst_flags", {bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof, busy,
                           frame_done, hdr_err, csum_err, timeout_err}, 0);
      chk("s6_rst_dims", {frame_width, frame_height}, 0);
      rst = 1'b0;
      tick();
      send_frame(4, 2, 0, 1, -1);
      wait_done("s6");
      check_counts("s6");
      // randomized traffic with gaps and backpressure
      gap_rnd = 1'b1;
      rdy_rnd = 1'b1;
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(0, 3)) begin
            nb = 8'($urandom);
            fifo.push_back(nb == 8'hA5 ? 8'h00 : nb);
         end
         w = $urandom_range(1, MW);
         h = $urandom_range(1, MH);
         if ($urandom_range(0, 5) == 0) begin
            kind = $urandom_range(0, 3);
            send_hdr(kind == 0 ? 0 : kind == 2 ? MW + 1 + $urandom_range(0, 5) : w,
                     kind == 1 ? 0 : kind == 3 ? MH + 1 + $urandom_range(0, 5) : h);
         end else begin
            send_frame(w, h, $urandom_range(0, 3) == 0, 0, -1);
         end
         wait_done("rnd");
         check_counts("rnd");
      end
      chk("final_exp_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
